gf180mcu_clkdiv_gen: RTL

- Programmable, glitch-free integer clock divider. Sits downstream of the clock-tree inverter/buffer cells and consumes the distributed clock.
- Produces a divided clock Q, its complement QN and a one-cycle period-end strobe for local logic.
- Divisor changes and stop requests take effect only at period boundaries, so Q/QN never emit runt pulses.

---
 rtl/gf180mcu_clkdiv_gen_if.sv | 26 ++
 rtl/gf180mcu_clkdiv_gen.sv | 127 ++++++++++++
 2 files changed

// File: rtl/gf180mcu_clkdiv_gen_if.sv
// Bus bundle for gf180mcu_clkdiv_gen.
// EN is a level run request sampled on every rising CLK edge: EN=1 starts or
// keeps the divider running, EN=0 asks it to stop at the end of the current
// divided period. The divider reports the stop as complete by dropping ACTIVE.
// DIV is sampled only at IDLE->RUN and at period boundaries.
interface gf180mcu_clkdiv_gen_if #(
   parameter int WIDTH = 4
) ();
   logic             EN;
   logic [WIDTH-1:0] DIV;
   logic             Q;
   logic             QN;
   logic             PEND;
   logic             ACTIVE;
   logic [1:0]       fsm_state;

   modport master (
      output EN, DIV,
      input  Q, QN, PEND, ACTIVE, fsm_state
   );

   modport slave (
      input  EN, DIV,
      output Q, QN, PEND, ACTIVE, fsm_state
   );
endinterface

// File: rtl/gf180mcu_clkdiv_gen.sv
// Glitch-free programmable integer clock divider.
// Divisor changes and stop requests only land on divided-period boundaries,
// so Q/QN never produce runt pulses. DIV values 0 and 1 act as 2.
// Optional macro GF180MCU_CLKDIV_DUTY50_EN adds a falling-edge stretch flop
// that gives exactly 50% duty for odd divisors.
// fsm_state encoding: 0 = IDLE, 1 = RUN, 2 = DRAIN.
module gf180mcu_clkdiv_gen #(
   parameter int WIDTH = 4
) (
   input logic                   CLK,
   input logic                   RN,
   gf180mcu_clkdiv_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div_q;
   logic             q_r;
   logic             qn_r;
   logic             pend_r;
   logic             active_r;

   logic [WIDTH-1:0] div_clamped;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] last;
   logic [WIDTH-1:0] hi;
   logic             at_end;
   logic             q_next;

   // Clamp the requested divisor and derive the per-period counting terms.
   always_comb begin
      div_clamped = (bus.DIV < DIV_MIN) ? DIV_MIN : bus.DIV;
      cnt_inc     = cnt + ONE;
      last        = div_q - ONE;
      hi          = div_q >> 1;
      at_end      = (cnt == last);
      q_next      = (cnt_inc < hi);
   end

   // Control FSM, period counter and all registered outputs.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state    <= IDLE;
         cnt      <= '0;
         div_q    <= DIV_MIN;
         q_r      <= 1'b0;
         qn_r     <= 1'b1;
         pend_r   <= 1'b0;
         active_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt    <= '0;
               pend_r <= 1'b0;
               if (bus.EN) begin
                  state    <= RUN;
                  div_q    <= div_clamped;
                  q_r      <= 1'b1;
                  qn_r     <= 1'b0;
                  active_r <= 1'b1;
               end else begin
                  div_q    <= DIV_MIN;
                  q_r      <= 1'b0;
                  qn_r     <= 1'b1;
                  active_r <= 1'b0;
               end
            end
            RUN, DRAIN: begin
               if (at_end) begin
                  cnt    <= '0;
                  pend_r <= 1'b0;
                  if (state == RUN && bus.EN) begin
                     // Next period starts; new divisor takes effect here.
                     div_q <= div_clamped;
                     q_r   <= 1'b1;
                     qn_r  <= 1'b0;
                  end else begin
                     // Stop lands exactly on the boundary.
                     state    <= IDLE;
                     div_q    <= DIV_MIN;
                     q_r      <= 1'b0;
                     qn_r     <= 1'b1;
                     active_r <= 1'b0;
                  end
               end else begin
                  cnt    <= cnt_inc;
                  q_r    <= q_next;
                  qn_r   <= ~q_next;
                  pend_r <= (cnt_inc == last);
                  state  <= bus.EN ? RUN : DRAIN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef GF180MCU_CLKDIV_DUTY50_EN
   logic qh;

   // Half-cycle stretch of the high phase; only used for odd divisors.
   always_ff @(negedge CLK or negedge RN) begin
      if (!RN) qh <= 1'b0;
      else     qh <= q_r & div_q[0];
   end

   assign bus.Q  = q_r | qh;
   assign bus.QN = qn_r & ~qh;
`else
   assign bus.Q  = q_r;
   assign bus.QN = qn_r;
`endif

   assign bus.PEND      = pend_r;
   assign bus.ACTIVE    = active_r;
   assign bus.fsm_state = state;

endmodule
